// File: rtl/gpio_in_pkg.sv
// gpio_in_pkg: register map, default base address and arming length for gpio_in_reader
package gpio_in_pkg;

    localparam logic [1:0]  OFF_DATA      = 2'd0;
    localparam logic [1:0]  OFF_RISE      = 2'd1;
    localparam logic [1:0]  OFF_FALL      = 2'd2;
    localparam logic [1:0]  OFF_IRQ_EN    = 2'd3;
    localparam logic [31:0] BASE_ADDR_DEF = 32'hFFFF_0010;
    localparam logic [1:0]  ARM_CYCLES    = 2'd3;

endpackage

// File: rtl/gpio_debounce_bit.sv
// gpio_debounce_bit: per-bit filter; accepts a new level after DEB_CNT consecutive differing ticks
module gpio_debounce_bit #(
    parameter int DEB_CNT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_tick,
    input  logic i_armed,
    input  logic i_sync,
    input  logic i_stb,
    output logic o_stb_nxt
);

    localparam int CW = $clog2(DEB_CNT + 1);

    logic [CW-1:0] r_cnt;
    logic          w_reached;

    assign w_reached = r_cnt == CW'(DEB_CNT);
    assign o_stb_nxt = (!i_armed || w_reached) ? i_sync : i_stb;

    // count ticks on which the synchronised input disagrees with the stable level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (!i_armed || w_reached)
            r_cnt <= '0;
        else if (i_tick)
            r_cnt <= (i_sync != i_stb) ? r_cnt + 1'b1 : '0;
    end

endmodule

// File: rtl/gpio_in_reader.sv
// gpio_in_reader: synchronised GPIO input capture with sticky edge flags, bus reads and level irq.
// Define GPIO_IN_DEBOUNCE_EN to insert a per-bit debounce filter between synchroniser and stable value.
module gpio_in_reader
    import gpio_in_pkg::*;
#(
    parameter int                         DATA_WIDTH      = 32,
    parameter int                         DATA_ADDR_WIDTH = 32,
    parameter logic [DATA_ADDR_WIDTH-1:0] BASE_ADDR       = DATA_ADDR_WIDTH'(BASE_ADDR_DEF),
    parameter int                         DEB_DIV         = 1000,
    parameter int                         DEB_CNT         = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [DATA_WIDTH-1:0]      gpio_i,
    input  logic                       data_rd_en,
    input  logic                       data_wr_en,
    input  logic [DATA_ADDR_WIDTH-1:0] data_addr,
    input  logic [DATA_WIDTH-1:0]      data_write,
    output logic [DATA_WIDTH-1:0]      data_read,
    output logic                       rd_hit,
    output logic                       irq
);

    logic [DATA_WIDTH-1:0] r_sync1, r_sync2, r_stb, r_rise, r_fall, r_irq_en;
    logic [DATA_WIDTH-1:0] w_stb_nxt, w_rise_evt, w_fall_evt, w_rdata;
    logic [1:0]            r_arm, w_off;
    logic                  w_armed, w_hit, w_rd, w_wr_en, w_clr_rise, w_clr_fall;
    logic                  w_unused_addr;

    assign w_armed       = r_arm == ARM_CYCLES;
    assign w_hit         = data_addr[DATA_ADDR_WIDTH-1:4] == BASE_ADDR[DATA_ADDR_WIDTH-1:4];
    assign w_off         = data_addr[3:2];
    assign w_rd          = data_rd_en && w_hit;
    assign w_wr_en       = data_wr_en && w_hit && w_off == OFF_IRQ_EN;
    assign w_clr_rise    = w_rd && w_off == OFF_RISE;
    assign w_clr_fall    = w_rd && w_off == OFF_FALL;
    assign w_unused_addr = ^data_addr[1:0];

`ifdef GPIO_IN_DEBOUNCE_EN
    localparam int PW = $clog2(DEB_DIV);

    logic [PW-1:0] r_pre;
    logic          w_tick;

    assign w_tick = r_pre == PW'(DEB_DIV - 1);

    // free-running prescaler producing one debounce sample tick every DEB_DIV cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_pre <= '0;
        else
            r_pre <= w_tick ? '0 : r_pre + 1'b1;
    end

    for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_deb
        gpio_debounce_bit #(.DEB_CNT(DEB_CNT)) u_deb (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_tick    (w_tick),
            .i_armed   (w_armed),
            .i_sync    (r_sync2[i]),
            .i_stb     (r_stb[i]),
            .o_stb_nxt (w_stb_nxt[i])
        );
    end
`else
    logic w_unused_deb;

    assign w_unused_deb = ^{DEB_DIV[0], DEB_CNT[0]};
    assign w_stb_nxt    = r_sync2;
`endif

    // edges compare the level being loaded into stb against the current stb, so a flag lands with stb
    assign w_rise_evt = w_armed ? (w_stb_nxt & ~r_stb) : '0;
    assign w_fall_evt = w_armed ? (~w_stb_nxt & r_stb) : '0;

    // read mux over the four-word register window
    always_comb begin
        w_rdata = (w_off == OFF_DATA) ? r_stb  :
                  (w_off == OFF_RISE) ? r_rise :
                  (w_off == OFF_FALL) ? r_fall : r_irq_en;
    end

    // two-flop synchroniser, stable value and post-reset arming counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_stb   <= '0;
            r_arm   <= '0;
        end else begin
            r_sync1 <= gpio_i;
            r_sync2 <= r_sync1;
            r_stb   <= w_stb_nxt;
            r_arm   <= w_armed ? r_arm : r_arm + 2'd1;
        end
    end

    // sticky edge flags; a new event in the clearing cycle survives the clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rise <= '0;
            r_fall <= '0;
        end else begin
            r_rise <= (r_rise & ~{DATA_WIDTH{w_clr_rise}}) | w_rise_evt;
            r_fall <= (r_fall & ~{DATA_WIDTH{w_clr_fall}}) | w_fall_evt;
        end
    end

    // interrupt enable mask, the only writable register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_irq_en <= '0;
        else if (w_wr_en)
            r_irq_en <= data_write;
    end

    // registered read return; pre-clear, pre-write values are returned
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_read <= '0;
            rd_hit    <= 1'b0;
        end else begin
            data_read <= w_rd ? w_rdata : '0;
            rd_hit    <= w_rd;
        end
    end

    // level interrupt from any enabled pending flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            irq <= 1'b0;
        else
            irq <= |((r_rise | r_fall) & r_irq_en);
    end

endmodule

// File: tb/tb_gpio_in_reader.sv
// tb_gpio_in_reader: scoreboard-driven bench for gpio_in_reader (debounce scenario under GPIO_IN_DEBOUNCE_EN)
module tb_gpio_in_reader;

    localparam logic [31:0] BASE = 32'hFFFF_0010;
    localparam logic [31:0] A_DATA = BASE;
    localparam logic [31:0] A_RISE = BASE + 32'h4;
    localparam logic [31:0] A_FALL = BASE + 32'h8;
    localparam logic [31:0] A_EN   = BASE + 32'hC;
`ifdef GPIO_IN_DEBOUNCE_EN
    localparam int SETTLE = 40;
`else
    localparam int SETTLE = 5;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] gpio_i = '0;
    logic        data_rd_en = 1'b0;
    logic        data_wr_en = 1'b0;
    logic [31:0] data_addr = '0;
    logic [31:0] data_write = '0;
    logic [31:0] data_read;
    logic        rd_hit;
    logic        irq;

    logic [32:0] sb[$];
    logic [32:0] exp;
    logic [31:0] cur, en_m, exp_f;
    int          vec = 0;
    int          miss = 0;

    gpio_in_reader #(.DEB_DIV(4), .DEB_CNT(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .gpio_i     (gpio_i),
        .data_rd_en (data_rd_en),
        .data_wr_en (data_wr_en),
        .data_addr  (data_addr),
        .data_write (data_write),
        .data_read  (data_read),
        .rd_hit     (rd_hit),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [31:0] a, input logic h, input logic [31:0] d);
        sb.push_back({h, d});
        data_addr  = a;
        data_rd_en = 1'b1;
        @(posedge clk);
        #1;
        data_rd_en = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        data_addr  = a;
        data_write = d;
        data_wr_en = 1'b1;
        @(posedge clk);
        #1;
        data_wr_en = 1'b0;
    endtask

    task automatic test_reset;
        gpio_i = 32'h0000_00FF;
        cur    = 32'h0000_00FF;
        en_m   = '0;
        rst_n  = 1'b0;
        idle(3);
        vec++; if ({data_read, rd_hit, irq} !== 34'd0) begin miss++; $display("FAIL in_reset: got %h/%b/%b want 0/0/0", data_read, rd_hit, irq); end
        rst_n = 1'b1;
        idle(6);
        rd(A_DATA, 1'b1, cur);
        exp = sb.pop_front(); vec++; if ({rd_hit, data_read} !== exp) begin miss++; $display("FAIL reset_data: got %b/%h want %b/%h", rd_hit, data_read, exp[32], exp[31:0]); end
        rd(A_RISE, 1'b1, 32'h0);
        exp = sb.pop_front(); vec++; if ({rd_hit, data_read} !== exp) begin miss++; $display("FAIL reset_rise: got %b/%h want %b/%h", rd_hit, data_read, exp[32], exp[31:0]); end
        rd(A_FALL, 1'b1, 32'h0);
        exp = sb.pop_front(); vec++; if ({rd_hit, data_read} !== exp) begin miss++; $display("FAIL reset_fall: got %b/%h want %b/%h", rd_hit, data_read, exp[32], exp[31:0]); end
        vec++; if (irq !== 1'b0) begin miss++; $display("FAIL reset_irq: got %b want 0", irq); end
    endtask

    task automatic test_rise_irq;
        gpio_i = '0;
        idle(SETTLE);
        rd(A_FALL, 1'b1, cur);
        exp = sb.pop_front(); vec++; if ({rd_hit, data_read} !== exp) begin miss++; $display("FAIL fall_all: got %b/%h want %b/%h", rd_hit, data_read, exp[32], exp[31:0]); end
        cur    = 32'h8;
        gpio_i = cur;
        idle(SETTLE);
        wr(A_EN, 32'h8);
        en_m = 32'h8;
        vec++; if (irq !== 1'b0) begin miss++; $display("FAIL irq_lag: got %b want 0", irq); end
        idle(1);
        vec++; if (irq !== 1'b1) begin miss++; $display("FAIL irq_set: got %b want 1", irq); end
        rd(A_RISE, 1'b1, 32'h8);
        exp = sb.pop_front(); vec++; if ({rd_hit, data_read} !== exp) begin miss++; $display("FAIL rise_b3: got %b/%h want %b/%h", rd_hit, data_read, exp[32], exp[31:0]); end
        rd(A_RISE, 1'b1, 32'h0);
        exp = sb.pop_front(); vec++; if ({rd_hit, data_read} !== exp) begin miss++; $display("FAIL rise_cleared: got %b/%h want %b/%h", rd_hit, data_read, exp[32], exp[31:0]); end
        vec++; if (irq !== 1'b0) begin miss++; $display("FAIL irq_drop: got %b want 0", irq); end
        rd(A_EN, 1'b1, en_m);
        exp = sb.pop_front(); vec++; if ({rd_hit, data_read} !== exp) begin miss++; $display("FAIL irq_en_rd: got %b/%h want %b/%h", rd_hit, data_read, exp[32], exp[31:0]); end
    endtask

    task automatic test_same_cycle;
        cur    = 32'h28;
        gpio_i = cur;
        idle(2);
        rd(A_RISE, 1'b1, 32'h0);
        exp = sb.pop_front(); vec++; if ({rd_hit, data_read} !== exp) begin miss++; $display("FAIL race_old: got %b/%h want %b/%h", rd_hit, data_read, exp[32], exp[31:0]); end
        rd(A_RISE, 1'b1, 32'h20);
        exp = sb.pop_front(); vec++; if ({rd_hit, data_read} !== exp) begin miss++; $display("FAIL race_kept: got %b/%h want %b/%h", rd_hit, data_read, exp[32], exp[31:0]); end
        sb.push_back({1'b1, en_m});
        data_addr  = A_EN;
        data_write = 32'h20;
        data_rd_en = 1'b1;
        data_wr_en = 1'b1;
        @(posedge clk);
        #1;
        data_rd_en = 1'b0;
        data_wr_en = 1'b0;
        en_m = 32'h20;
        exp = sb.pop_front(); vec++; if ({rd_hit, data_read} !== exp) begin miss++; $display("FAIL rdwr_old: got %b/%h want %b/%h", rd_hit, data_read, exp[32], exp[31:0]); end
        rd(A_EN, 1'b1, en_m);
        exp = sb.pop_front(); vec++; if ({rd_hit, data_read} !== exp) begin miss++; $display("FAIL rdwr_new: got %b/%h want %b/%h", rd_hit, data_read, exp[32], exp[31:0]); end
    endtask

    task automatic test_miss;
        exp_f  = cur;
        cur    = '0;
        gpio_i = cur;
        idle(SETTLE);
        vec++; if (irq !== |(exp_f & en_m)) begin miss++; $display("FAIL fall_irq: got %b want %b", irq, |(exp_f & en_m)); end
        rd(BASE + 32'h28, 1'b0, 32'h0);
        exp = sb.pop_front(); vec++; if ({rd_hit, data_read} !== exp) begin miss++; $display("FAIL miss_rd: got %b/%h want %b/%h", rd_hit, data_read, exp[32], exp[31:0]); end
        wr(A_RISE, 32'hFFFF_FFFF);
        rd(A_RISE, 1'b1, 32'h0);
        exp = sb.pop_front(); vec++; if ({rd_hit, data_read} !== exp) begin miss++; $display("FAIL ro_write: got %b/%h want %b/%h", rd_hit, data_read, exp[32], exp[31:0]); end
        rd(BASE + 32'hA, 1'b1, exp_f);
        exp = sb.pop_front(); vec++; if ({rd_hit, data_read} !== exp) begin miss++; $display("FAIL fall_kept: got %b/%h want %b/%h", rd_hit, data_read, exp[32], exp[31:0]); end
        rd(A_FALL, 1'b1, 32'h0);
        exp = sb.pop_front(); vec++; if ({rd_hit, data_read} !== exp) begin miss++; $display("FAIL fall_cleared: got %b/%h want %b/%h", rd_hit, data_read, exp[32], exp[31:0]); end
    endtask

    task automatic test_async_reset;
        cur    = 32'h81;
        gpio_i = cur;
        idle(SETTLE);
        wr(A_EN, 32'hFF);
        en_m = 32'hFF;
        idle(2);
        vec++; if (irq !== 1'b1) begin miss++; $display("FAIL pre_rst_irq: got %b want 1", irq); end
        rd(A_EN, 1'b1, en_m);
        exp = sb.pop_front(); vec++; if ({rd_hit, data_read} !== exp) begin miss++; $display("FAIL pre_rst_rd: got %b/%h want %b/%h", rd_hit, data_read, exp[32], exp[31:0]); end
        #1 rst_n = 1'b0;
        #1;
        vec++; if ({data_read, rd_hit, irq} !== 34'd0) begin miss++; $display("FAIL async_rst: got %h/%b/%b want 0/0/0", data_read, rd_hit, irq); end
        idle(2);
        rst_n = 1'b1;
        en_m  = '0;
        idle(6);
        rd(A_EN, 1'b1, en_m);
        exp = sb.pop_front(); vec++; if ({rd_hit, data_read} !== exp) begin miss++; $display("FAIL post_rst_en: got %b/%h want %b/%h", rd_hit, data_read, exp[32], exp[31:0]); end
        rd(A_DATA, 1'b1, cur);
        exp = sb.pop_front(); vec++; if ({rd_hit, data_read} !== exp) begin miss++; $display("FAIL post_rst_data: got %b/%h want %b/%h", rd_hit, data_read, exp[32], exp[31:0]); end
        rd(A_RISE, 1'b1, 32'h0);
        exp = sb.pop_front(); vec++; if ({rd_hit, data_read} !== exp) begin miss++; $display("FAIL post_rst_rise: got %b/%h want %b/%h", rd_hit, data_read, exp[32], exp[31:0]); end
    endtask

    task automatic test_debounce;
        int lat;
        gpio_i = '0;
        idle(SETTLE);
        rd(A_RISE, 1'b1, 32'h0);
        void'(sb.pop_front());
        gpio_i = 32'h1;
        idle(10);
        gpio_i = '0;
        idle(SETTLE);
        rd(A_DATA, 1'b1, 32'h0);
        exp = sb.pop_front(); vec++; if ({rd_hit, data_read} !== exp) begin miss++; $display("FAIL glitch_data: got %b/%h want %b/%h", rd_hit, data_read, exp[32], exp[31:0]); end
        rd(A_RISE, 1'b1, 32'h0);
        exp = sb.pop_front(); vec++; if ({rd_hit, data_read} !== exp) begin miss++; $display("FAIL glitch_rise: got %b/%h want %b/%h", rd_hit, data_read, exp[32], exp[31:0]); end
        lat        = 0;
        gpio_i     = 32'h1;
        data_addr  = A_DATA;
        data_rd_en = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (data_read[0] === 1'b1) begin
                lat = k;
                break;
            end
        end
        data_rd_en = 1'b0;
        vec++; if (lat < 16 || lat > 20) begin miss++; $display("FAIL deb_latency: got %0d cycles want 16..20", lat); end
        rd(A_RISE, 1'b1, 32'h1);
        exp = sb.pop_front(); vec++; if ({rd_hit, data_read} !== exp) begin miss++; $display("FAIL deb_rise: got %b/%h want %b/%h", rd_hit, data_read, exp[32], exp[31:0]); end
    endtask

    initial begin
        test_reset();
        test_rise_irq();
`ifndef GPIO_IN_DEBOUNCE_EN
        test_same_cycle();
`endif
        test_miss();
        test_async_reset();
`ifdef GPIO_IN_DEBOUNCE_EN
        test_debounce();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
